// File: rtl/first_nios2_system_keys_in.sv
// ---------------------------------------------------------------------------
// first_nios2_system_keys_in
//
// Avalon-MM slave input PIO for the key/switch pins. This is the read-side
// companion to the system's output PIO. The external pins pass through a
// synchronizer. Selected edges are latched per bit in an edge-capture
// register, and a maskable, level-sensitive interrupt goes to the Nios II
// CPU. The slave has zero wait states: readdata is decoded combinationally
// from registered state.
//
// Register map (unused high bits read as 0):
//   0  DATA     RO   synchronized pin levels (writes ignored)
//   1  -        reads 0, writes ignored
//   2  IRQMASK  RW   per-bit interrupt enable
//   3  EDGECAP  R/W1C captured edges
//
// Parameters:
//   WIDTH        number of pins / register bits (1..32)
//   EDGE_TYPE    0 = rising, 1 = falling, 2 = any edge captured
//   SYNC_STAGES  synchronizer depth (2..4)
//
// Ports:
//   clk         system clock
//   reset_n     asynchronous, active-low reset
//   address     register select
//   chipselect  slave select
//   write_n     active-low write strobe
//   writedata   write data (only [WIDTH-1:0] is used)
//   in_port     asynchronous external inputs
//   readdata    read data, combinational, 0 when not selected
//   irq         level interrupt, active-high
// ---------------------------------------------------------------------------
module first_nios2_system_keys_in #(
  parameter int WIDTH       = 4,
  parameter int EDGE_TYPE   = 1,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  localparam logic [1:0] ADDR_DATA    = 2'd0;
  localparam logic [1:0] ADDR_IRQMASK = 2'd2;
  localparam logic [1:0] ADDR_EDGECAP = 2'd3;

  // Edge detection is enabled once the synchronizer and the delay register
  // both hold real pin samples. This takes SYNC_STAGES+1 cycles after reset.
  localparam logic [2:0] PRIME_LAST = 3'(SYNC_STAGES + 1);

  // Synchronizer chain. Element [0] is the first capturing stage.
  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_chain_q, sync_chain_d;
  logic [WIDTH-1:0]                  sync_q;
  logic [WIDTH-1:0]                  prev_q, prev_d;
  logic [2:0]                        prime_cnt_q, prime_cnt_d;
  logic [WIDTH-1:0]                  irq_mask_q, irq_mask_d;
  logic [WIDTH-1:0]                  edge_capture_q, edge_capture_d;

  logic             wr_en;
  logic             prime_done;
  logic [WIDTH-1:0] edge_hit;
  logic [WIDTH-1:0] clr;

  // Only writedata[WIDTH-1:0] is decoded. The remaining bits are folded
  // here on purpose.
  logic unused_writedata;
  assign unused_writedata = ^writedata;

  assign sync_q     = sync_chain_q[SYNC_STAGES-1];
  assign wr_en      = chipselect && !write_n;
  assign prime_done = (prime_cnt_q == PRIME_LAST);

  // Next-state logic.
  // NOTE: every signal gets a default first. Then no path through the block
  // leaves a signal unassigned, and no latch is inferred.
  always_comb begin
    sync_chain_d    = sync_chain_q;
    sync_chain_d[0] = in_port;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      sync_chain_d[i] = sync_chain_q[i-1];
    end

    prev_d      = sync_q;
    prime_cnt_d = prime_done ? prime_cnt_q : prime_cnt_q + 3'd1;

    if (EDGE_TYPE == 0) begin
      edge_hit = sync_q & ~prev_q;
    end else if (EDGE_TYPE == 1) begin
      edge_hit = ~sync_q & prev_q;
    end else begin
      edge_hit = sync_q ^ prev_q;
    end
    if (!prime_done) begin
      edge_hit = '0;
    end

    clr = '0;
    if (wr_en && address == ADDR_EDGECAP) begin
      clr = writedata[WIDTH-1:0];
    end
    // A new edge takes priority over a simultaneous clear of the same bit.
    // This way an event is never lost.
    edge_capture_d = edge_hit | (edge_capture_q & ~clr);

    irq_mask_d = irq_mask_q;
    if (wr_en && address == ADDR_IRQMASK) begin
      irq_mask_d = writedata[WIDTH-1:0];
    end
  end

  // NOTE: state is updated with non-blocking assignments. Every flop then
  // samples the pre-edge values, which is what makes the synchronizer chain
  // shift by one stage per clock.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_chain_q   <= '0;
      prev_q         <= '0;
      prime_cnt_q    <= '0;
      irq_mask_q     <= '0;
      edge_capture_q <= '0;
    end else begin
      sync_chain_q   <= sync_chain_d;
      prev_q         <= prev_d;
      prime_cnt_q    <= prime_cnt_d;
      irq_mask_q     <= irq_mask_d;
      edge_capture_q <= edge_capture_d;
    end
  end

  // Zero-wait-state read mux.
  always_comb begin
    readdata = '0;
    if (chipselect) begin
      case (address)
        ADDR_DATA:    readdata[WIDTH-1:0] = sync_q;
        ADDR_IRQMASK: readdata[WIDTH-1:0] = irq_mask_q;
        ADDR_EDGECAP: readdata[WIDTH-1:0] = edge_capture_q;
        default:      readdata = '0;
      endcase
    end
  end

  // The interrupt is taken straight from registers. It therefore drops as
  // soon as reset is asserted.
  assign irq = |(edge_capture_q & irq_mask_q);

endmodule

// File: tb/tb_first_nios2_system_keys_in.sv
// ---------------------------------------------------------------------------
// tb_first_nios2_system_keys_in
//
// Directed bench for the keys input PIO. The configuration is WIDTH=4,
// falling-edge capture and a 2-stage synchronizer.
// It covers: prime gating after reset, capture latency, write-1-to-clear,
// mask gating of irq, edge-wins-over-clear, the register decode, and reset
// asserted mid-operation.
// ---------------------------------------------------------------------------
module tb_first_nios2_system_keys_in;

  localparam int WIDTH       = 4;
  localparam int EDGE_TYPE   = 1;
  localparam int SYNC_STAGES = 2;

  logic             clk = 1'b0;
  logic             reset_n;
  logic [1:0]       address;
  logic             chipselect;
  logic             write_n;
  logic [31:0]      writedata;
  logic [WIDTH-1:0] in_port;
  logic [31:0]      readdata;
  logic             irq;

  int checks = 0;
  int errors = 0;

  first_nios2_system_keys_in #(
    .WIDTH      (WIDTH),
    .EDGE_TYPE  (EDGE_TYPE),
    .SYNC_STAGES(SYNC_STAGES)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .address   (address),
    .chipselect(chipselect),
    .write_n   (write_n),
    .writedata (writedata),
    .in_port   (in_port),
    .readdata  (readdata),
    .irq       (irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [3:0] pins;
    logic       cs;
    logic [1:0] addr;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // The write commits on the next rising edge. The task returns 1 ns after it.
  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    chipselect = 1'b1;
    write_n    = 1'b0;
    address    = a;
    writedata  = d;
    tick();
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    chipselect = 1'b1;
    write_n    = 1'b1;
    address    = a;
    #1;
    d = readdata;
    chipselect = 1'b0;
  endtask

  task automatic check_reg(input string name, input logic [1:0] a, input logic [31:0] exp);
    logic [31:0] d;
    bus_read(a, d);
    check(name, d, exp);
  endtask

  task automatic check_irq(input string name, input logic exp);
    check(name, {31'b0, irq}, {31'b0, exp});
  endtask

  initial begin
    logic [31:0] d;

    vecs[0] = '{"data_A",      4'hA, 1'b1, 2'd0, 32'h0000_000A};
    vecs[1] = '{"data_5",      4'h5, 1'b1, 2'd0, 32'h0000_0005};
    vecs[2] = '{"data_0",      4'h0, 1'b1, 2'd0, 32'h0000_0000};
    vecs[3] = '{"data_F",      4'hF, 1'b1, 2'd0, 32'h0000_000F};
    vecs[4] = '{"addr1_zero",  4'h3, 1'b1, 2'd1, 32'h0000_0000};
    vecs[5] = '{"cs_low_zero", 4'h3, 1'b0, 2'd0, 32'h0000_0000};
    vecs[6] = '{"data_6",      4'h6, 1'b1, 2'd0, 32'h0000_0006};
    vecs[7] = '{"data_A2",     4'hA, 1'b1, 2'd0, 32'h0000_000A};

    reset_n    = 1'b0;
    address    = '0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
    in_port    = 4'hF;

    // 1. Pins held high through reset release: nothing may be captured.
    tick(3);
    check_irq("irq_in_reset", 1'b0);
    check_reg("edgecap_in_reset", 2'd3, 32'h0);
    reset_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      check_reg("prime_edgecap", 2'd3, 32'h0);
      check_irq("prime_irq", 1'b0);
    end
    check_reg("data_after_prime", 2'd0, 32'h0000_000F);

    // IRQMASK readback: only the low WIDTH bits are kept.
    bus_write(2'd2, 32'hFFFF_FFF5);
    check_reg("irqmask_readback", 2'd2, 32'h0000_0005);

    // 2. Bit1 falls with only bit1 enabled. Check the exact capture latency.
    bus_write(2'd2, 32'h2);
    in_port = 4'hD;
    tick();
    check_reg("data_one_stage", 2'd0, 32'h0000_000F);
    check_reg("edgecap_lat1", 2'd3, 32'h0);
    tick();
    check_reg("data_synced", 2'd0, 32'h0000_000D);
    check_reg("edgecap_lat2", 2'd3, 32'h0);
    check_irq("irq_lat2", 1'b0);
    tick();
    check_reg("edgecap_bit1", 2'd3, 32'h2);
    check_irq("irq_bit1", 1'b1);
    bus_write(2'd3, 32'h2);
    check_reg("edgecap_cleared", 2'd3, 32'h0);
    check_irq("irq_cleared", 1'b0);

    // 3. Masked capture still latches. The mask then controls irq.
    bus_write(2'd2, 32'h0);
    in_port = 4'hC;
    tick(3);
    check_reg("edgecap_masked", 2'd3, 32'h1);
    check_irq("irq_masked", 1'b0);
    bus_write(2'd2, 32'h1);
    check_irq("irq_unmasked", 1'b1);
    bus_write(2'd2, 32'h0);
    check_irq("irq_mask_off", 1'b0);
    bus_write(2'd2, 32'h1);
    check_irq("irq_mask_on", 1'b1);
    bus_write(2'd3, 32'h1);
    check_irq("irq_after_w1c", 1'b0);
    check_reg("edgecap_w1c_bit0", 2'd3, 32'h0);

    // 4. An edge and a clear on the same bit in the same cycle: the edge wins.
    in_port = 4'h8;
    tick(3);
    check_reg("edgecap_bit2", 2'd3, 32'h4);
    in_port = 4'hC;
    tick(3);
    check_reg("rise_ignored", 2'd3, 32'h4);
    in_port = 4'h8;
    tick(2);
    bus_write(2'd3, 32'h4);
    check_reg("edge_beats_clear", 2'd3, 32'h4);
    bus_write(2'd3, 32'h1);
    check_reg("clear_other_bit", 2'd3, 32'h4);
    bus_write(2'd3, 32'h4);
    check_reg("clear_bit2", 2'd3, 32'h0);

    // 5. Register decode from a table.
    for (int i = 0; i < 8; i++) begin
      in_port = vecs[i].pins;
      tick(3);
      chipselect = vecs[i].cs;
      write_n    = 1'b1;
      address    = vecs[i].addr;
      #1;
      check(vecs[i].name, readdata, vecs[i].exp);
      chipselect = 1'b0;
    end
    bus_write(2'd0, 32'h5);
    check_reg("data_write_ignored", 2'd0, 32'h0000_000A);
    bus_write(2'd1, 32'hFFFF_FFFF);
    check_reg("addr1_write_ignored", 2'd1, 32'h0);

    // 6. Asynchronous reset in the middle of a cycle while irq is high.
    bus_write(2'd3, 32'hF);
    bus_write(2'd2, 32'hF);
    in_port = 4'hF;
    tick(3);
    in_port = 4'h0;
    tick(3);
    check_reg("edgecap_all", 2'd3, 32'hF);
    check_irq("irq_before_reset", 1'b1);
    @(posedge clk);
    #4;
    reset_n = 1'b0;
    #1;
    check_irq("irq_async_reset", 1'b0);
    tick(2);
    reset_n = 1'b1;
    tick();
    check_reg("irqmask_after_reset", 2'd2, 32'h0);
    check_reg("edgecap_after_reset", 2'd3, 32'h0);

    // Capture works again once priming completes.
    bus_write(2'd2, 32'h1);
    in_port = 4'h1;
    tick(4);
    check_reg("edgecap_post_reset_quiet", 2'd3, 32'h0);
    in_port = 4'h0;
    tick(3);
    check_reg("edgecap_post_reset", 2'd3, 32'h1);
    check_irq("irq_post_reset", 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
